matrix_scroller: RTL and testbench
==================================

MATRIX_SCROLLER -- requirements
Module: matrix_scroller

Interface
REQ-001 Parameter N_COLS, default 5, number of LED matrix columns driven.
REQ-002 Parameter N_ROWS, default 7, number of LED matrix rows driven.
REQ-003 Parameter MSG_COLS, default 40, length of the stored message in columns, which must be at least N_COLS.
REQ-004 Parameter FRAMES_PER_STEP, default 8, number of complete frames per one-column scroll step, which must be at least 1.
REQ-005 CLK  input  1  the single system clock; all flops SHALL be clocked on its rising edge.
REQ-006 RST  input  1  reset, asynchronous and active-high.
REQ-007 DIV_IN  input  1  slow square wave from the frequency divider output; it SHALL be treated as asynchronous data and SHALL NOT be used as a clock.
REQ-008 EN  input  1  display enable, level-sensitive.
REQ-009 COL  output  N_COLS  column drivers, one-hot active-low; all ones means all columns are off.
REQ-010 ROW  output  N_ROWS  row pattern for the driven column, active-high.
REQ-011 FRAME_DONE  output  1  one-CLK pulse when the last column of a frame completes.

Function
REQ-012 DIV_IN SHALL pass through a 2-flop synchronizer followed by a history flop; internal tick SHALL be high for exactly one CLK cycle on each 0->1 transition of the synchronized value.
REQ-013 Tick latency SHALL be 3 CLK cycles: DIV_IN rises before edge k, and tick is high during the cycle after edge k+2.
REQ-014 The FSM SHALL have the states IDLE, DRIVE and BLANK.
REQ-015 IDLE: COL is all ones and ROW=0. On tick with EN=1, the FSM SHALL go to DRIVE with col_idx=0.
REQ-016 DRIVE: COL[col_idx]=0 and all other COL bits are 1; ROW is loaded on entry with rom_data(addr) and held for the whole state. On tick, the FSM SHALL go to BLANK.
REQ-017 BLANK lasts exactly 1 CLK cycle: COL is all ones and ROW=0. It then goes to DRIVE with col_idx+1, or with 0 if col_idx=N_COLS-1.
REQ-018 The ROM address SHALL be addr=(offset+col_idx) mod MSG_COLS, computed without overflow for any legal parameter set.
REQ-019 FRAME_DONE SHALL pulse in the cycle the FSM enters BLANK from DRIVE with col_idx=N_COLS-1.
REQ-020 A frame counter SHALL count FRAME_DONE pulses. When it reaches FRAMES_PER_STEP it SHALL clear to 0 and offset SHALL increment, wrapping from MSG_COLS-1 to 0.
REQ-021 The new offset SHALL take effect on the next DRIVE entry; a frame is never rendered with mixed offsets.
REQ-022 If EN=0 in any state, the next CLK edge SHALL enter IDLE and set col_idx=0. offset and the frame counter SHALL be held.
REQ-023 If a tick coincides with EN falling, EN takes priority and the FSM enters IDLE.
REQ-024 A tick arriving during BLANK SHALL be ignored, because BLANK is a single cycle and the tick spacing is at least 2 cycles.
REQ-025 At most one COL bit SHALL be low in any cycle.

Reset
REQ-026 While RST=1: COL is all ones, ROW=0, FRAME_DONE=0, state is IDLE, and col_idx, offset, the frame counter, the synchronizer and the history flop are all 0.
REQ-027 If DIV_IN is already high at reset release, exactly one tick SHALL occur 3 cycles after release; this is the decided behaviour.
REQ-028 RST asserted mid-operation SHALL blank the outputs immediately, without waiting for CLK.

Structure
REQ-029 Package matrix_pkg SHALL hold the FSM state type, the default N_COLS, N_ROWS and MSG_COLS constants, and a clog2-based address-width function.
REQ-030 Sub-module message_rom SHALL map a column address to an N_ROWS-bit pattern, combinationally; its contents are fixed at synthesis.
REQ-031 The synchronizer, edge detector, FSM, counters and address adder SHALL live in matrix_scroller.

Verification
REQ-032 Reset release with EN=1 and DIV_IN toggling every 28 CLK cycles:
  - first DRIVE with COL=11110 after the first tick;
  - ROW=rom[0].
REQ-033 Five ticks plus blanking:
  - COL sequence 11110, 11111, 11101, 11111, 11011, and so on up to 01111;
  - FRAME_DONE pulses once, on the BLANK after COL=01111.
REQ-034 8 frames completed:
  - offset=1;
  - next column 0 shows rom[1];
  - after 40 steps (320 frames), offset wraps to 0 and column 4 at offset 39 shows rom[3].
REQ-035 EN dropped while COL=11011:
  - next cycle COL=11111, ROW=0, state IDLE, offset held;
  - EN restored, then the next tick gives COL=11110.
REQ-036 RST pulsed mid-DRIVE between CLK edges:
  - COL is all ones immediately;
  - after release with DIV_IN high, exactly one tick occurs 3 cycles later.
REQ-037 DIV_IN glitch shorter than 1 CLK cycle that is not sampled high: no tick, state unchanged.

Source files
------------

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types, default geometry and width helper for the LED matrix scroller
//
// Contents:
//   state_e        scan FSM states (IDLE, DRIVE, BLANK)
//   DEF_N_COLS     default number of matrix columns
//   DEF_N_ROWS     default number of matrix rows
//   DEF_MSG_COLS   default stored message length in columns
//   addr_width()   bits needed to index 'depth' entries, never less than 1
package matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    localparam int DEF_N_COLS   = 5;
    localparam int DEF_N_ROWS   = 7;
    localparam int DEF_MSG_COLS = 40;

    // A single-entry table still needs a one-bit index, so clamp at 1.
    function automatic int addr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/message_rom.sv
// rtl/message_rom.sv - combinational column-pattern table holding the scrolled message
//
// Ports:
//   addr_i  [AW-1:0]      column address within the message
//   data_o  [N_ROWS-1:0]  row pattern for that column, bit 0 is the top row
//
// The message "KELOWRD!" is stored as eight 5-column glyphs of 7 rows.
// Rows beyond the 7-row font read as 0; addresses past the font repeat
// the low address bits so larger message parameters still see a pattern.
module message_rom
    import matrix_pkg::*;
#(
    parameter int N_ROWS   = DEF_N_ROWS,
    parameter int MSG_COLS = DEF_MSG_COLS,
    parameter int AW       = addr_width(MSG_COLS)
) (
    input  logic [AW-1:0]     addr_i,
    output logic [N_ROWS-1:0] data_o
);

    logic [6:0] glyph;

    always_comb begin
        glyph = 7'(addr_i);
        case (int'(addr_i))
            // K
            0:  glyph = 7'h7F;
            1:  glyph = 7'h08;
            2:  glyph = 7'h14;
            3:  glyph = 7'h22;
            4:  glyph = 7'h41;
            // E
            5:  glyph = 7'h7F;
            6:  glyph = 7'h49;
            7:  glyph = 7'h49;
            8:  glyph = 7'h49;
            9:  glyph = 7'h41;
            // L
            10: glyph = 7'h7F;
            11: glyph = 7'h40;
            12: glyph = 7'h40;
            13: glyph = 7'h40;
            14: glyph = 7'h40;
            // O
            15: glyph = 7'h3E;
            16: glyph = 7'h41;
            17: glyph = 7'h41;
            18: glyph = 7'h41;
            19: glyph = 7'h3E;
            // W
            20: glyph = 7'h3F;
            21: glyph = 7'h40;
            22: glyph = 7'h38;
            23: glyph = 7'h40;
            24: glyph = 7'h3F;
            // R
            25: glyph = 7'h7F;
            26: glyph = 7'h09;
            27: glyph = 7'h19;
            28: glyph = 7'h29;
            29: glyph = 7'h46;
            // D
            30: glyph = 7'h7F;
            31: glyph = 7'h41;
            32: glyph = 7'h41;
            33: glyph = 7'h22;
            34: glyph = 7'h1C;
            // !
            35: glyph = 7'h00;
            36: glyph = 7'h00;
            37: glyph = 7'h5F;
            38: glyph = 7'h00;
            39: glyph = 7'h00;
            default: glyph = 7'(addr_i);
        endcase
    end

    for (genvar r = 0; r < N_ROWS; r++) begin : g_row
        if (r < 7) begin : g_font
            assign data_o[r] = glyph[r];
        end else begin : g_pad
            assign data_o[r] = 1'b0;
        end
    end

endmodule

// File: rtl/matrix_scroller.sv
// rtl/matrix_scroller.sv - column-scanned LED matrix driver that scrolls a stored message
//
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset
//   DIV_IN      slow square wave from the divider, treated as asynchronous data
//   EN          display enable, level-sensitive
//   COL         one-hot active-low column drivers, all ones = all off
//   ROW         active-high row pattern for the driven column
//   FRAME_DONE  one-cycle pulse in the blanking cycle after the last column
//
// Each rising edge of DIV_IN produces one internal tick. A tick starts the scan
// from IDLE, or ends the current DRIVE; every DRIVE is followed by one BLANK
// cycle before the next column is driven.
module matrix_scroller
    import matrix_pkg::*;
#(
    parameter int N_COLS          = DEF_N_COLS,
    parameter int N_ROWS          = DEF_N_ROWS,
    parameter int MSG_COLS        = DEF_MSG_COLS,
    parameter int FRAMES_PER_STEP = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              DIV_IN,
    input  logic              EN,
    output logic [N_COLS-1:0] COL,
    output logic [N_ROWS-1:0] ROW,
    output logic              FRAME_DONE
);

    localparam int AW = addr_width(MSG_COLS);
    localparam int CW = addr_width(N_COLS);
    localparam int FW = addr_width(FRAMES_PER_STEP + 1);

    localparam logic [CW-1:0] LAST_COL   = CW'(N_COLS - 1);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(MSG_COLS - 1);
    localparam logic [AW:0]   MSG_LEN    = (AW + 1)'(MSG_COLS);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);

    // ------------------------------------------------------------------
    // DIV_IN synchronizer, history flop and registered rising-edge tick
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic hist_q;
    logic tick_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= DIV_IN;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            // Registered so the FSM sees the tick one cycle after the
            // synchronized edge, giving a fixed 3-cycle input latency.
            tick_q  <= sync2_q & ~hist_q;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_e            state_q,     state_d;
    logic [CW-1:0]     col_idx_q,   col_idx_d;
    logic [AW-1:0]     offset_q,    offset_d;
    logic [FW-1:0]     frame_cnt_q, frame_cnt_d;
    logic [N_ROWS-1:0] row_q,       row_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            col_idx_q   <= '0;
            offset_q    <= '0;
            frame_cnt_q <= '0;
            row_q       <= '0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            offset_q    <= offset_d;
            frame_cnt_q <= frame_cnt_d;
            row_q       <= row_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame counter and scroll offset
    // ------------------------------------------------------------------
    logic frame_done;

    assign frame_done = (state_q == ST_BLANK) && (col_idx_q == LAST_COL);

    // The offset can only move in the BLANK after the last column, so any
    // frame is always rendered with one offset value from start to end.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        offset_d    = offset_q;
        if (frame_done) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                offset_d    = (offset_q == LAST_ADDR) ? '0 : offset_q + 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // ROM address for the column about to be driven
    // ------------------------------------------------------------------
    logic [CW-1:0]     col_next;
    logic [CW-1:0]     col_load;
    logic [AW:0]       addr_sum;
    logic [AW:0]       addr_mod;
    logic [AW-1:0]     rom_addr;
    logic [N_ROWS-1:0] rom_data;

    assign col_next = (col_idx_q == LAST_COL) ? '0 : col_idx_q + 1'b1;
    // Only IDLE->DRIVE (column 0) and BLANK->DRIVE (next column) load ROW.
    assign col_load = (state_q == ST_BLANK) ? col_next : '0;

    // offset < MSG_COLS and column < N_COLS <= MSG_COLS, so the sum fits in
    // one extra bit and a single conditional subtract performs the modulo.
    always_comb begin
        addr_sum = {1'b0, offset_d} + (AW + 1)'(col_load);
        addr_mod = (addr_sum >= MSG_LEN) ? addr_sum - MSG_LEN : addr_sum;
        rom_addr = addr_mod[AW-1:0];
    end

    message_rom #(
        .N_ROWS  (N_ROWS),
        .MSG_COLS(MSG_COLS),
        .AW      (AW)
    ) u_rom (
        .addr_i(rom_addr),
        .data_o(rom_data)
    );

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_d     = row_q;
        if (!EN) begin
            // Disable wins over any tick in the same cycle.
            state_d   = ST_IDLE;
            col_idx_d = '0;
            row_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    row_d = '0;
                    if (tick_q) begin
                        state_d   = ST_DRIVE;
                        col_idx_d = '0;
                        row_d     = rom_data;
                    end
                end
                ST_DRIVE: begin
                    if (tick_q) begin
                        state_d = ST_BLANK;
                        row_d   = '0;
                    end
                end
                ST_BLANK: begin
                    // Always exactly one cycle; a tick here is ignored.
                    state_d   = ST_DRIVE;
                    col_idx_d = col_next;
                    row_d     = rom_data;
                end
                default: begin
                    state_d   = ST_IDLE;
                    col_idx_d = '0;
                    row_d     = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all derived from reset-cleared flops so RST blanks at once
    // ------------------------------------------------------------------
    always_comb begin
        COL = '1;
        if (state_q == ST_DRIVE) begin
            for (int c = 0; c < N_COLS; c++) begin
                if (col_idx_q == CW'(c)) begin
                    COL[c] = 1'b0;
                end
            end
        end
    end

    assign ROW        = row_q;
    assign FRAME_DONE = frame_done;

endmodule

// File: tb/tb_matrix_scroller.sv
// tb/tb_matrix_scroller.sv - self-checking bench for matrix_scroller against a behavioural model
module tb_matrix_scroller;

    localparam int N_COLS   = 5;
    localparam int N_ROWS   = 7;
    localparam int MSG_COLS = 40;
    localparam int FPS      = 8;

    localparam int M_IDLE  = 0;
    localparam int M_DRIVE = 1;
    localparam int M_BLANK = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              DIV_IN;
    logic              EN;
    logic [N_COLS-1:0] COL;
    logic [N_ROWS-1:0] ROW;
    logic              FRAME_DONE;

    always #5 CLK = ~CLK;

    matrix_scroller #(
        .N_COLS         (N_COLS),
        .N_ROWS         (N_ROWS),
        .MSG_COLS       (MSG_COLS),
        .FRAMES_PER_STEP(FPS)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DIV_IN    (DIV_IN),
        .EN        (EN),
        .COL       (COL),
        .ROW       (ROW),
        .FRAME_DONE(FRAME_DONE)
    );

    logic [6:0] msg [MSG_COLS];

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: scan mode, column, offset and frame totals, with a
    // record of DIV_IN as sampled at each clock edge (bit 0 = latest edge).
    int         m_mode;
    int         m_col;
    int         m_off;
    int         m_frames;
    int         m_frames_total;
    logic [3:0] m_samp;

    task automatic model_reset();
        m_mode         = M_IDLE;
        m_col          = 0;
        m_off          = 0;
        m_frames       = 0;
        m_frames_total = 0;
        m_samp         = '0;
    endtask

    task automatic model_edge();
        logic tick;
        // A rise sampled three edges ago is acted on at this edge.
        tick = m_samp[2] & ~m_samp[3];
        if (m_mode == M_BLANK && m_col == N_COLS - 1) begin
            m_frames_total++;
            m_frames++;
            if (m_frames == FPS) begin
                m_frames = 0;
                m_off    = (m_off + 1) % MSG_COLS;
            end
        end
        if (!EN) begin
            m_mode = M_IDLE;
            m_col  = 0;
        end else begin
            case (m_mode)
                M_IDLE:  if (tick) begin m_mode = M_DRIVE; m_col = 0; end
                M_DRIVE: if (tick) m_mode = M_BLANK;
                default: begin m_mode = M_DRIVE; m_col = (m_col + 1) % N_COLS; end
            endcase
        end
        m_samp = {m_samp[2:0], DIV_IN};
    endtask

    function automatic logic [N_COLS-1:0] exp_col();
        logic [N_COLS-1:0] v;
        v = '1;
        if (m_mode == M_DRIVE) v[m_col] = 1'b0;
        return v;
    endfunction

    function automatic logic [N_ROWS-1:0] exp_row();
        if (m_mode == M_DRIVE) return msg[(m_off + m_col) % MSG_COLS];
        return '0;
    endfunction

    // Observation log for the directed sequence checks.
    bit                log_on = 0;
    logic [N_COLS-1:0] last_col = '1;
    logic [N_COLS-1:0] last_drive_col = '1;
    logic [N_COLS-1:0] fd_prev_col = '0;
    logic [N_COLS-1:0] col_log [$];
    int                fd_count = 0;

    task automatic cycle(input logic div, input logic en, input logic rst);
        DIV_IN = div;
        EN     = en;
        RST    = rst;
        if (rst) model_reset();
        @(posedge CLK);
        if (rst) model_reset();
        else model_edge();
        @(negedge CLK);
        check_eq("col", 32'(COL), 32'(exp_col()));
        check_eq("row", 32'(ROW), 32'(exp_row()));
        check_eq("frame_done", 32'(FRAME_DONE), 32'(m_mode == M_BLANK && m_col == N_COLS - 1));
        if (log_on) begin
            if (COL !== last_col) col_log.push_back(COL);
            if (FRAME_DONE) begin
                fd_count++;
                fd_prev_col = last_drive_col;
            end
        end
        last_col = COL;
        if (COL !== '1) last_drive_col = COL;
    endtask

    int fast_i = 0;

    task automatic fast_cycle(input logic en);
        cycle(logic'((fast_i / 2) % 2), en, 1'b0);
        fast_i++;
    endtask

    initial begin
        logic [N_COLS-1:0] seq_exp [11];
        logic [N_ROWS-1:0] first_row, row_off1, row_39, row_wrap, reen_row;
        bit                got_first, got_off1, got_39, got_zero, found;
        int                saved_off, drive_at, rises;
        logic [N_COLS-1:0] prev;

        msg = '{7'h7F, 7'h08, 7'h14, 7'h22, 7'h41,
                7'h7F, 7'h49, 7'h49, 7'h49, 7'h41,
                7'h7F, 7'h40, 7'h40, 7'h40, 7'h40,
                7'h3E, 7'h41, 7'h41, 7'h41, 7'h3E,
                7'h3F, 7'h40, 7'h38, 7'h40, 7'h3F,
                7'h7F, 7'h09, 7'h19, 7'h29, 7'h46,
                7'h7F, 7'h41, 7'h41, 7'h22, 7'h1C,
                7'h00, 7'h00, 7'h5F, 7'h00, 7'h00};
        seq_exp = '{5'b11110, 5'b11111, 5'b11101, 5'b11111, 5'b11011, 5'b11111,
                    5'b10111, 5'b11111, 5'b01111, 5'b11111, 5'b11110};
        model_reset();

        // Reset state
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        check_eq("rst_col", 32'(COL), 32'h1F);
        check_eq("rst_row", 32'(ROW), 32'h0);
        check_eq("rst_fd", 32'(FRAME_DONE), 32'h0);

        // Slow divider: DIV_IN toggles every 28 cycles
        log_on    = 1;
        got_first = 0;
        first_row = '0;
        for (int i = 0; i < 340; i++) begin
            cycle(logic'((i / 28) % 2), 1'b1, 1'b0);
            if (!got_first && COL == 5'b11110) begin
                first_row = ROW;
                got_first = 1;
            end
        end
        log_on = 0;
        check_eq("first_row", 32'(first_row), 32'h7F);
        check_eq("seq_len", col_log.size(), 11);
        for (int k = 0; k < 11; k++) begin
            if (k < col_log.size()) check_eq($sformatf("seq%0d", k), 32'(col_log[k]), 32'(seq_exp[k]));
        end
        check_eq("fd_count", fd_count, 1);
        check_eq("fd_after_col", 32'(fd_prev_col), 32'(5'b01111));

        // Fast divider: scroll steps, offset 1 and full wrap of the message
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        got_off1 = 0; got_39 = 0; got_zero = 0;
        row_off1 = '0; row_39 = '0; row_wrap = '0;
        for (int i = 0; i < 8000 && !got_zero; i++) begin
            fast_cycle(1'b1);
            if (!got_off1 && m_off == 1 && COL == 5'b11110) begin
                row_off1 = ROW;
                got_off1 = 1;
            end
            if (!got_39 && m_off == 39 && COL == 5'b01111) begin
                row_39 = ROW;
                got_39 = 1;
            end
            if (m_frames_total >= 320 && m_off == 0 && COL == 5'b11110) begin
                row_wrap = ROW;
                got_zero = 1;
            end
        end
        check_eq("off1_seen", 32'(got_off1), 32'h1);
        check_eq("off1_row", 32'(row_off1), 32'h08);
        check_eq("off39_col4_row", 32'(row_39), 32'h22);
        check_eq("wrap_seen", 32'(got_zero), 32'h1);
        check_eq("wrap_row", 32'(row_wrap), 32'h7F);

        // EN dropped while column 2 is driven
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            fast_cycle(1'b1);
            if (COL == 5'b11011) found = 1;
        end
        check_eq("col2_seen", 32'(found), 32'h1);
        saved_off = m_off;
        fast_cycle(1'b0);
        check_eq("en_off_col", 32'(COL), 32'h1F);
        check_eq("en_off_row", 32'(ROW), 32'h0);
        for (int i = 0; i < 12; i++) fast_cycle(1'b0);
        found = 0;
        reen_row = '0;
        for (int i = 0; i < 40 && !found; i++) begin
            fast_cycle(1'b1);
            if (COL !== 5'h1F) begin
                found = 1;
                prev = COL;
                reen_row = ROW;
            end
        end
        check_eq("reen_seen", 32'(found), 32'h1);
        check_eq("reen_col", 32'(prev), 32'(5'b11110));
        check_eq("reen_row_held_off", 32'(reen_row), 32'(msg[saved_off]));

        // Asynchronous reset between clock edges while driving
        #2 RST = 1'b1;
        #1;
        check_eq("async_col", 32'(COL), 32'h1F);
        check_eq("async_row", 32'(ROW), 32'h0);
        check_eq("async_fd", 32'(FRAME_DONE), 32'h0);
        model_reset();
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        drive_at = -1;
        rises    = 0;
        prev     = COL;
        for (int k = 1; k <= 30; k++) begin
            cycle(1'b1, 1'b1, 1'b0);
            if (COL !== prev) begin
                rises++;
                if (drive_at < 0) drive_at = k;
            end
            prev = COL;
        end
        check_eq("rel_drive_cycle", drive_at, 4);
        check_eq("rel_changes", rises, 1);

        // Narrow DIV_IN glitch between edges must not tick
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
        #1 DIV_IN = 1'b1;
        #2 DIV_IN = 1'b0;
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0);
        check_eq("glitch_col", 32'(COL), 32'(5'b11110));

        // Random divider activity and enable drops
        for (int i = 0; i < 3000; i++) begin
            cycle(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 15) != 0), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
